// File: rtl/div_ctrl_if.sv
// Request/response handshake plus the command/result path to the unsigned divider core.
// The slave side is div_ctrl; the master side is the pipeline and the core together.
interface div_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic         op_signed;
    logic         op_w;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  result;
    logic         flush;
    logic         div_start;
    logic [63:0]  div_a;
    logic [63:0]  div_b;
    logic         div_done;
    logic [127:0] div_c;

    modport slave (
        input  in_valid, op_signed, op_w, a, b, out_ready, flush, div_done, div_c,
        output in_ready, out_valid, result, div_start, div_a, div_b
    );

    modport master (
        output in_valid, op_signed, op_w, a, b, out_ready, flush, div_done, div_c,
        input  in_ready, out_valid, result, div_start, div_a, div_b
    );
endinterface

// File: rtl/div_ctrl.sv
// Signed/unsigned 32/64-bit divide sequencer around an unsigned multi-cycle divider core.
// Operands are reduced to magnitudes on accept and the quotient sign is fixed up on return.
module div_ctrl (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic [63:0] q_signed, q_fix;
    logic [63:0] div_a_q, div_b_q, result_q;
    logic        neg_q, op_w_q, neg_nxt, b_zero, accept;
    logic        unused_rem;

    // W form works on the low word, widened so one 64-bit magnitude path serves both widths.
    assign a_ext = bus.op_w ? (bus.op_signed ? {{32{bus.a[31]}}, bus.a[31:0]} : {32'h0, bus.a[31:0]})
                            : bus.a;
    assign b_ext = bus.op_w ? (bus.op_signed ? {{32{bus.b[31]}}, bus.b[31:0]} : {32'h0, bus.b[31:0]})
                            : bus.b;
    assign a_mag   = (bus.op_signed && a_ext[63]) ? (~a_ext + 64'd1) : a_ext;
    assign b_mag   = (bus.op_signed && b_ext[63]) ? (~b_ext + 64'd1) : b_ext;
    assign neg_nxt = bus.op_signed & (a_ext[63] ^ b_ext[63]);
    assign b_zero  = (b_ext == 64'd0);

    // INT_MIN / -1 falls out naturally: magnitude 2^(w-1), positive sign, truncated to width.
    assign q_signed = neg_q ? (~bus.div_c[63:0] + 64'd1) : bus.div_c[63:0];
    assign q_fix    = op_w_q ? {32'h0, q_signed[31:0]} : q_signed;
    assign unused_rem = ^bus.div_c[127:64];

    assign bus.in_ready  = (state == IDLE) && !bus.flush && !reset;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == RESP);
    assign bus.div_start = (state == START);
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.result    = result_q;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = b_zero ? RESP : START;
            end
            START: begin
                state_nxt = bus.flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (bus.div_done)   state_nxt = bus.flush ? IDLE : RESP;
                else if (bus.flush) state_nxt = DRAIN;
            end
            RESP: begin
                if (bus.flush || bus.out_ready) state_nxt = IDLE;
            end
            DRAIN: begin
                if (bus.div_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_a_q  <= '0;
            div_b_q  <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            op_w_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                div_a_q  <= a_mag;
                div_b_q  <= b_mag;
                neg_q    <= neg_nxt;
                op_w_q   <= bus.op_w;
                result_q <= '0;
            end
            if (state == WAIT && bus.div_done && !bus.flush) begin
                result_q <= q_fix;
            end
        end
    end
endmodule
